// File: rtl/axi_packet_rr_mux.sv
// Packet-atomic N:1 AXI-stream arbiter. The grant is held from the first beat to tlast,
// so packets never interleave. Round-robin or fixed-priority selection.
module axi_packet_rr_mux #(
  parameter int WIDTH     = 32,
  parameter int NUM_PORTS = 4,
  parameter int PRIO      = 0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       clear,
  input  logic [NUM_PORTS*WIDTH-1:0] i_tdata,
  input  logic [NUM_PORTS-1:0]       i_tlast,
  input  logic [NUM_PORTS-1:0]       i_tvalid,
  output logic [NUM_PORTS-1:0]       i_tready,
  output logic [WIDTH-1:0]           o_tdata,
  output logic                       o_tlast,
  output logic                       o_tvalid,
  input  logic                       o_tready,
  output logic [2:0]                 grant,
  output logic                       busy,
  output logic [15:0]                pkt_count
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t                   state_q;
  logic [2:0]               grant_q;
  logic [2:0]               last_grant_q;
  logic [15:0]              pkt_count_q;

  logic [2:0]               start;
  logic [2*NUM_PORTS-1:0]   req_dbl;
  logic [NUM_PORTS-1:0]     req_rot;
  logic [3:0]               win_sum;
  logic [2:0]               win;
  logic                     found;

  logic [WIDTH-1:0]         sel_data;
  logic                     sel_last;
  logic                     sel_valid;

  // Round-robin searches a rotated copy of the requests starting just past the last grant.
  always_comb begin
    start   = (last_grant_q == 3'(NUM_PORTS - 1)) ? '0 : last_grant_q + 3'd1;
    req_dbl = {i_tvalid, i_tvalid};
    req_rot = NUM_PORTS'(req_dbl >> start);
    win_sum = '0;
    win     = '0;
    found   = 1'b0;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      if (PRIO != 0) begin
        if (!found && i_tvalid[i]) begin
          win   = 3'(i);
          found = 1'b1;
        end
      end else begin
        if (!found && req_rot[i]) begin
          win_sum = 4'(start) + 4'(i);
          if (win_sum >= 4'(NUM_PORTS)) win_sum = win_sum - 4'(NUM_PORTS);
          win   = win_sum[2:0];
          found = 1'b1;
        end
      end
    end
  end

  always_comb begin
    sel_data  = '0;
    sel_last  = 1'b0;
    sel_valid = 1'b0;
    for (int unsigned k = 0; k < NUM_PORTS; k++) begin
      if (grant_q == 3'(k)) begin
        sel_data  = i_tdata[k*WIDTH +: WIDTH];
        sel_last  = i_tlast[k];
        sel_valid = i_tvalid[k];
      end
    end
  end

  always_comb begin
    o_tdata  = sel_data;
    o_tlast  = 1'b0;
    o_tvalid = 1'b0;
    i_tready = '0;
    if (state_q == GRANT) begin
      o_tlast  = sel_last;
      o_tvalid = sel_valid;
      for (int unsigned k = 0; k < NUM_PORTS; k++) begin
        i_tready[k] = (grant_q == 3'(k)) & o_tready;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      last_grant_q <= 3'(NUM_PORTS - 1);
      pkt_count_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (found) begin
            grant_q <= win;
            state_q <= GRANT;
          end
        end
        GRANT: begin
          if (o_tvalid && o_tready && o_tlast) begin
            state_q      <= IDLE;
            last_grant_q <= grant_q;
            pkt_count_q  <= pkt_count_q + 16'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign grant     = grant_q;
  assign busy      = (state_q == GRANT);
  assign pkt_count = pkt_count_q;

endmodule

// File: tb/tb_axi_packet_rr_mux.sv
// Bench for axi_packet_rr_mux: a round-robin and a fixed-priority instance, each checked
// every cycle against a transaction-level model, plus directed scenarios pinned by literals.
module tb_axi_packet_rr_mux;
  localparam int W = 32;
  localparam int N = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           reset, clear;
  logic [N*W-1:0] td [2];
  logic [N-1:0]   tl [2], tv [2], tr [2];
  logic [W-1:0]   od [2];
  logic           ol [2], ov [2], otr [2];
  logic [2:0]     gr [2];
  logic           bz [2];
  logic [15:0]    pc [2];

  axi_packet_rr_mux #(.WIDTH(W), .NUM_PORTS(N), .PRIO(0)) u_rr (
    .clk(clk), .reset(reset), .clear(clear),
    .i_tdata(td[0]), .i_tlast(tl[0]), .i_tvalid(tv[0]), .i_tready(tr[0]),
    .o_tdata(od[0]), .o_tlast(ol[0]), .o_tvalid(ov[0]), .o_tready(otr[0]),
    .grant(gr[0]), .busy(bz[0]), .pkt_count(pc[0]));

  axi_packet_rr_mux #(.WIDTH(W), .NUM_PORTS(N), .PRIO(1)) u_fp (
    .clk(clk), .reset(reset), .clear(clear),
    .i_tdata(td[1]), .i_tlast(tl[1]), .i_tvalid(tv[1]), .i_tready(tr[1]),
    .o_tdata(od[1]), .o_tlast(ol[1]), .o_tvalid(ov[1]), .o_tready(otr[1]),
    .grant(gr[1]), .busy(bz[1]), .pkt_count(pc[1]));

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // model: cur = granted port or -1 when idle
  int m_cur [2], m_gnt [2], m_last [2], m_cnt [2];
  int glog0 [$];
  int glog1 [$];

  // sources
  int         rem [2][N];
  int         seq [2][N];
  logic [N-1:0] en [2];
  int         fixlen, start_pct, rdy_pct;

  // observations on the round-robin instance
  int beats0, lasts0, first_ov;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic model_reset(input int d);
    m_cur[d]  = -1;
    m_gnt[d]  = 0;
    m_last[d] = N - 1;
    m_cnt[d]  = 0;
  endtask

  task automatic drive();
    for (int d = 0; d < 2; d++) begin
      for (int p = 0; p < N; p++) begin
        if (rem[d][p] == 0 && en[d][p] && $urandom_range(0, 99) < start_pct)
          rem[d][p] = (fixlen != 0) ? fixlen : int'($urandom_range(1, 4));
        tv[d][p]         = (rem[d][p] > 0);
        tl[d][p]         = (rem[d][p] == 1);
        td[d][p*W +: W]  = {8'(d), 8'(p), 16'(seq[d][p])};
      end
      otr[d] = ($urandom_range(0, 99) < rdy_pct);
    end
  endtask

  task automatic step();
    logic         e_ov, e_ol, e_bz;
    logic [N-1:0] e_tr;
    int           k;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      e_ov = 1'b0; e_ol = 1'b0; e_bz = 1'b0; e_tr = '0;
      if (m_cur[d] >= 0) begin
        e_ov = tv[d][m_cur[d]];
        e_ol = tl[d][m_cur[d]];
        e_bz = 1'b1;
        e_tr[m_cur[d]] = otr[d];
      end
      chk("o_tvalid", 64'(ov[d]), 64'(e_ov));
      chk("o_tlast", 64'(ol[d]), 64'(e_ol));
      chk("i_tready", 64'(tr[d]), 64'(e_tr));
      chk("busy", 64'(bz[d]), 64'(e_bz));
      chk("grant", 64'(gr[d]), 64'(m_gnt[d]));
      chk("pkt_count", 64'(pc[d]), 64'(m_cnt[d]));
      if (e_ov) chk("o_tdata", 64'(od[d]), 64'(td[d][m_cur[d]*W +: W]));

      if (d == 0) begin
        if (ov[0] && first_ov < 0) first_ov = cyc;
        if (ov[0] && otr[0]) begin
          beats0++;
          if (ol[0]) lasts0++;
        end
      end

      if (reset || clear) begin
        model_reset(d);
      end else if (m_cur[d] < 0) begin
        if (tv[d] != '0) begin
          k = -1;
          for (int i = 0; i < N; i++) begin
            int c;
            c = (d == 1) ? i : (m_last[d] + 1 + i) % N;
            if (k < 0 && tv[d][c]) k = c;
          end
          m_cur[d] = k;
          m_gnt[d] = k;
          if (d == 0) glog0.push_back(k); else glog1.push_back(k);
        end
      end else if (e_ov && otr[d] && e_ol) begin
        m_last[d] = m_cur[d];
        m_cur[d]  = -1;
        m_cnt[d]  = (m_cnt[d] + 1) % 65536;
      end

      for (int p = 0; p < N; p++) begin
        if (tv[d][p] && tr[d][p]) begin
          rem[d][p]--;
          seq[d][p]++;
        end
        if (reset || clear) rem[d][p] = 0;
      end
    end
    cyc++;
    @(posedge clk);
    #1;
    drive();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  int c0, n;

  initial begin
    reset = 1'b1; clear = 1'b0;
    fixlen = 0; start_pct = 100; rdy_pct = 100;
    for (int d = 0; d < 2; d++) begin
      en[d] = '0;
      model_reset(d);
      for (int p = 0; p < N; p++) begin rem[d][p] = 0; seq[d][p] = 0; end
    end
    beats0 = 0; lasts0 = 0; first_ov = -1;
    drive();
    repeat (2) step();

    // reset state
    chk("rst_pkt_count", 64'(pc[0]), 64'd0);
    chk("rst_busy", 64'(bz[0]), 64'd0);
    chk("rst_grant", 64'(gr[0]), 64'd0);
    chk("rst_o_tvalid", 64'(ov[0]), 64'd0);
    chk("rst_i_tready", 64'(tr[0]), 64'd0);

    // single 4-beat packet on port 2
    reset = 1'b0;
    rem[0][2] = 4; rem[1][2] = 4;
    drive();
    c0 = cyc; beats0 = 0; lasts0 = 0; first_ov = -1;
    repeat (8) step();
    chk("single_first_ov_latency", 64'(first_ov - c0), 64'd1);
    chk("single_beats", 64'(beats0), 64'd4);
    chk("single_tlasts", 64'(lasts0), 64'd1);
    chk("single_grant", 64'(gr[0]), 64'd2);
    chk("single_pkt_count", 64'(pc[0]), 64'd1);
    chk("single_busy_end", 64'(bz[0]), 64'd0);

    // round-robin fairness, 2-beat packets on all ports
    en[0] = '1; en[1] = '1; fixlen = 2;
    do_reset();
    glog0.delete(); glog1.delete();
    n = 0;
    while (pc[0] != 16'd8 && n < 100) begin step(); n++; end
    chk("rr_cycles_for_8", 64'(n), 64'd24);
    chk("fp_pkt_count_8", 64'(pc[1]), 64'd8);
    for (int i = 0; i < 8; i++) begin
      chk("rr_order", 64'((glog0.size() > i) ? glog0[i] : -1), 64'(i % 4));
      chk("fp_order", 64'((glog1.size() > i) ? glog1[i] : -1), 64'd0);
    end

    // fixed priority: ports 1 and 3 contend
    en[0] = 4'b1010; en[1] = 4'b1010;
    do_reset();
    glog1.delete();
    repeat (20) step();
    for (int i = 0; i < 5; i++)
      chk("fp_only_port1", 64'((glog1.size() > i) ? glog1[i] : -1), 64'd1);
    en[0] = 4'b1000; en[1] = 4'b1000;
    glog1.delete();
    repeat (8) step();
    chk("fp_port3_after", 64'((glog1.size() > 0) ? glog1[0] : -1), 64'd3);

    // clear mid-packet
    en[0] = '0; en[1] = '0; fixlen = 0;
    do_reset();
    rem[0][1] = 4; rem[1][1] = 4;
    drive();
    repeat (3) step();
    clear = 1'b1;
    step();
    clear = 1'b0;
    chk("clr_o_tvalid", 64'(ov[0]), 64'd0);
    chk("clr_busy", 64'(bz[0]), 64'd0);
    chk("clr_pkt_count", 64'(pc[0]), 64'd0);
    for (int d = 0; d < 2; d++) begin rem[d][0] = 2; rem[d][1] = 2; end
    drive();
    step();
    chk("clr_next_grant_rr", 64'(gr[0]), 64'd0);
    chk("clr_next_grant_fp", 64'(gr[1]), 64'd0);

    // randomized traffic with backpressure and occasional clear
    en[0] = '1; en[1] = '1; fixlen = 0; start_pct = 40; rdy_pct = 60;
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      clear = ($urandom_range(0, 199) == 0);
      step();
    end
    clear = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/axi_packet_rr_mux.md
Name: axi_packet_rr_mux

Overview:
- Packet-atomic N:1 AXI-stream arbiter.
- Shares one downstream datapath between NUM_PORTS requesters. The downstream datapath is typically a block-RAM AXI FIFO feeding the DDR/accelerator path.
- Grants one input at a time and holds the grant until that input's tlast beat is accepted, so packets never interleave.
- Supports round-robin or fixed-priority scheduling.

Parameters:
- WIDTH, 32: data width per stream.
- NUM_PORTS, 4: number of input streams; legal range 2..8.
- PRIO, 0: 0 = round-robin; 1 = fixed priority, lowest index wins.

Ports:
- clk  input  1  clock
- reset  input  1  reset, synchronous, active-high
- clear  input  1  synchronous soft clear; same effect as reset
- i_tdata  input  NUM_PORTS*WIDTH  port k occupies bits [k*WIDTH +: WIDTH]
- i_tlast  input  NUM_PORTS  end-of-packet per port
- i_tvalid  input  NUM_PORTS  valid per port
- i_tready  output  NUM_PORTS  ready per port
- o_tdata  output  WIDTH  muxed data
- o_tlast  output  1  muxed tlast
- o_tvalid  output  1  muxed valid
- o_tready  input  1  downstream ready (e.g. ~full of the FIFO)
- grant  output  3  index of the currently granted port; zero-extended
- busy  output  1  high while in state GRANT
- pkt_count  output  16  packets forwarded since reset/clear; wraps

Behaviour:
- Reset/clear values:
  - state = IDLE, grant = 0, busy = 0, pkt_count = 0.
  - last_grant = NUM_PORTS-1, so port 0 has first priority under round-robin.
  - o_tvalid = 0 and i_tready = all 0 (both follow from IDLE).
- State IDLE:
  - o_tvalid = 0, o_tlast = 0, i_tready = all 0; o_tdata is don't-care.
  - If any i_tvalid is set, pick a winner and register it into grant; next state is GRANT.
  - Round-robin: winner is the first port with i_tvalid set, searching from (last_grant+1) mod NUM_PORTS upward with wrap.
  - Fixed priority: winner is the lowest index with i_tvalid set.
  - Arbitration latency: 1 cycle from a valid request in IDLE to the first possible transfer.
- State GRANT:
  - Purely combinational pass-through from the granted port g, with no added pipeline latency:
    - o_tdata = i_tdata[g], o_tlast = i_tlast[g], o_tvalid = i_tvalid[g].
    - i_tready[g] = o_tready; every other i_tready = 0.
  - A beat transfers when o_tvalid & o_tready.
  - Transfer with o_tlast = 1: next state IDLE, last_grant <= g, pkt_count <= pkt_count+1 (0xFFFF wraps to 0x0000).
  - Transfer with o_tlast = 0: remain in GRANT.
  - If the granted port drops i_tvalid mid-packet, the grant is held indefinitely; no timeout.
- Inter-packet gap: exactly one IDLE cycle between consecutive packets, even from the same port. Sustained throughput is L/(L+1) for L-beat packets.
- Single-beat packet (tlast on the first beat): GRANT lasts 1 cycle if o_tready=1.
- Requests arriving while in GRANT have no effect until the return to IDLE.
- Reset/clear take priority over all other activity:
  - Applied mid-packet, the packet is abandoned with no tlast emitted.
  - Upstream must also be cleared.
  - The state returns to IDLE on the next edge.
- Ports beyond NUM_PORTS do not exist; grant never exceeds NUM_PORTS-1.
- Stability: o_tdata, o_tlast and o_tvalid depend only on the granted port's signals, so the AXI rule that valid/data hold until ready is preserved if the source obeys it.

Test Plan:
- Single port, PRIO=0: port 2 sends a 4-beat packet A0..A3 with o_tready=1 → grant=2; o_tvalid rises 1 cycle after i_tvalid[2]; 4 consecutive beats out; tlast on A3; pkt_count=1; busy falls the cycle after A3.
- Round-robin fairness: all 4 ports continuously offer 2-beat packets after reset → grant order 0,1,2,3,0,1…; exactly one idle cycle between packets; pkt_count=8 after 8 packets.
- Fixed priority (PRIO=1): ports 1 and 3 continuously valid → only port 1 is served; port 3 is served only after port 1 deasserts i_tvalid in IDLE.
- Backpressure: 3-beat packet with o_tready toggling 1,0,0,1,1 → no beat lost or duplicated; i_tready[g] mirrors o_tready each cycle; other i_tready stay 0.
- Non-interleave: port 0 sends a 5-beat packet while port 1 asserts valid at beat 2 → all 5 port-0 beats emitted contiguously before any port-1 beat; port 1 starts after 1 idle cycle.
- Clear mid-packet: pulse clear after beat 2 of 4 on port 1 → next cycle o_tvalid=0, busy=0, pkt_count=0; the next request from ports 0 and 1 together grants port 0.
